dp_rr_scheduler: RTL and testbench

- Shares one start/done-handshake datapath unit between NREQ requesters using round-robin arbitration.
- Sequences each job through the phases arbitrate, load operand, start, wait for done, and respond.
- A watchdog aborts jobs whose datapath never signals done.
- Sits between requester blocks and a single datapath instance, replacing per-datapath standalone controllers.

---
 rtl/dp_rr_scheduler_if.sv | 32 +++
 rtl/dp_rr_scheduler.sv | 124 ++++++++++++
 tb/tb_dp_rr_scheduler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dp_rr_scheduler_if.sv
// Requester and datapath signals shared by the round-robin scheduler.
interface dp_rr_scheduler_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8
);
  localparam int unsigned IW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic               err;
  logic [DW-1:0]      rsp_data;
  logic [IW-1:0]      gnt_id;
  logic               busy;
  logic               dp_ld;
  logic [DW-1:0]      dp_data_in;
  logic               dp_start;
  logic               dp_done;
  logic [DW-1:0]      dp_result;

  // Environment side: requesters plus the datapath unit
  modport master (
    output req, req_data, dp_done, dp_result,
    input  ack, err, rsp_data, gnt_id, busy, dp_ld, dp_data_in, dp_start
  );

  // Scheduler side
  modport slave (
    input  req, req_data, dp_done, dp_result,
    output ack, err, rsp_data, gnt_id, busy, dp_ld, dp_data_in, dp_start
  );
endinterface

// File: rtl/dp_rr_scheduler.sv
// Round-robin scheduler sharing one start/done datapath between NREQ requesters,
// with a WAIT watchdog that aborts jobs whose datapath never reports done.
module dp_rr_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned TMO  = 255
) (
  input  logic             clk,
  input  logic             rst,
  dp_rr_scheduler_if.slave bus
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned TW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] gnt_q;
  logic [IW-1:0] rr_ptr;
  logic [TW-1:0] timer;
  logic          tmo_flag;
  logic [DW-1:0] rsp_q;
  logic [IW-1:0] win_c;
  logic          found_c;
  logic          tmo_hit_c;

  assign tmo_hit_c = (timer == TW'(TMO - 1));

  // First active request at or above the rr pointer, wrapping modulo NREQ
  always_comb begin
    int unsigned idx;
    win_c   = '0;
    found_c = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_ptr) + i) % NREQ;
      if (!found_c && bus.req[idx]) begin
        found_c = 1'b1;
        win_c   = IW'(idx);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found_c) state_nxt = LOAD;
      LOAD:    state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (bus.dp_done || tmo_hit_c) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore strobes decoded from the state register
  always_comb begin
    bus.busy     = 1'b0;
    bus.dp_ld    = 1'b0;
    bus.dp_start = 1'b0;
    bus.ack      = '0;
    bus.err      = 1'b0;
    unique case (state)
      IDLE:  ;
      LOAD:  begin bus.busy = 1'b1; bus.dp_ld    = 1'b1; end
      START: begin bus.busy = 1'b1; bus.dp_start = 1'b1; end
      WAIT:  bus.busy = 1'b1;
      RESP:  begin
        bus.busy       = 1'b1;
        bus.ack[gnt_q] = 1'b1;
        bus.err        = tmo_flag;
      end
      default: ;
    endcase
  end

  // Grant, rr pointer, watchdog timer and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q    <= '0;
      rr_ptr   <= '0;
      timer    <= '0;
      tmo_flag <= 1'b0;
      rsp_q    <= '0;
    end else begin
      unique case (state)
        IDLE:  if (found_c) gnt_q <= win_c;
        START: timer <= '0;
        WAIT: begin
          if (bus.dp_done) begin
            rsp_q    <= bus.dp_result;
            tmo_flag <= 1'b0;
          end else if (tmo_hit_c) begin
            tmo_flag <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RESP:  rr_ptr <= (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + IW'(1);
        default: ;
      endcase
    end
  end

  assign bus.gnt_id     = gnt_q;
  assign bus.rsp_data   = rsp_q;
  assign bus.dp_data_in = bus.req_data[gnt_q*DW +: DW];

endmodule

// File: tb/tb_dp_rr_scheduler.sv
// Directed bench for dp_rr_scheduler (NREQ=4, DW=8, TMO=8).
module tb_dp_rr_scheduler;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  dp_rr_scheduler_if #(.NREQ(4), .DW(8)) bus();

  dp_rr_scheduler #(.NREQ(4), .DW(8), .TMO(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One job from IDLE (request already applied): done arrives on WAIT cycle 'waits'
  task automatic run_job(input int id, input logic [7:0] res, input int waits);
    logic [31:0] rd;
    rd = bus.req_data;
    tick();
    chk("load_gnt",   32'(bus.gnt_id), 32'(id));
    chk("load_ld",    32'(bus.dp_ld), 32'h1);
    chk("load_busy",  32'(bus.busy), 32'h1);
    chk("load_data",  32'(bus.dp_data_in), (rd >> (id * 8)) & 32'hFF);
    tick();
    chk("start_st",   32'(bus.dp_start), 32'h1);
    chk("start_ld",   32'(bus.dp_ld), 32'h0);
    tick();
    for (int i = 1; i < waits; i++) tick();
    chk("wait_ack",   32'(bus.ack), 32'h0);
    chk("wait_busy",  32'(bus.busy), 32'h1);
    bus.dp_done   = 1'b1;
    bus.dp_result = res;
    tick();
    chk("resp_ack",   32'(bus.ack), 32'h1 << id);
    chk("resp_err",   32'(bus.err), 32'h0);
    chk("resp_rsp",   32'(bus.rsp_data), 32'(res));
    chk("resp_gnt",   32'(bus.gnt_id), 32'(id));
    chk("resp_strb",  32'({bus.dp_ld, bus.dp_start}), 32'h0);
    bus.dp_done = 1'b0;
    tick();
    chk("idle_busy",  32'(bus.busy), 32'h0);
    chk("idle_ack",   32'(bus.ack), 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst           = 1'b0;
    bus.req       = '0;
    bus.req_data  = {8'h43, 8'h72, 8'h5A, 8'h19};
    bus.dp_done   = 1'b0;
    bus.dp_result = '0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_ack",  32'(bus.ack), 32'h0);
    chk("rst_gnt",  32'(bus.gnt_id), 32'h0);
    chk("rst_rsp",  32'(bus.rsp_data), 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // 1: single request, done on the third WAIT cycle
    bus.req = 4'b0010;
    run_job(1, 8'hA5, 3);
    bus.req = 4'b0000;
    tick();
    chk("t1_hold_rsp", 32'(bus.rsp_data), 32'hA5);
    chk("t1_hold_gnt", 32'(bus.gnt_id), 32'h1);

    // 2: all requesters held from a fresh pointer -> 0,1,2,3,0
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    bus.req = 4'b1111;
    run_job(0, 8'h10, 1);
    run_job(1, 8'h11, 1);
    run_job(2, 8'h12, 1);
    run_job(3, 8'h13, 1);
    run_job(0, 8'h14, 1);

    // 3: pointer after requester 2 is 3, so 0101 wraps to 0 then 2
    bus.req = 4'b0100;
    run_job(2, 8'h33, 2);
    bus.req = 4'b0101;
    run_job(0, 8'h44, 1);
    run_job(2, 8'hA5, 1);
    bus.req = 4'b0000;

    // 4: watchdog timeout, response in WAIT-relative cycle 9 with err=1
    bus.req = 4'b0001;
    tick();
    chk("t4_gnt", 32'(bus.gnt_id), 32'h0);
    tick();
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t4_wait_ack", 32'(bus.ack), 32'h0);
    end
    tick();
    chk("t4_ack", 32'(bus.ack), 32'h1);
    chk("t4_err", 32'(bus.err), 32'h1);
    chk("t4_rsp", 32'(bus.rsp_data), 32'hA5);
    bus.req = 4'b0000;
    tick();
    chk("t4_err_clr", 32'(bus.err), 32'h0);

    // 5: done on the last WAIT cycle wins over timeout
    bus.req = 4'b0100;
    run_job(2, 8'h77, 8);
    bus.req = 4'b0000;

    // 6: asynchronous reset mid-WAIT, then spurious done in IDLE
    bus.req = 4'b0010;
    tick();
    tick();
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("t6_busy",  32'(bus.busy), 32'h0);
    chk("t6_strb",  32'({bus.dp_ld, bus.dp_start, bus.err}), 32'h0);
    chk("t6_ack",   32'(bus.ack), 32'h0);
    chk("t6_rsp",   32'(bus.rsp_data), 32'h0);
    bus.req = 4'b0000;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_ack", 32'(bus.ack), 32'h0);
    end
    bus.dp_done   = 1'b1;
    bus.dp_result = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_spur_busy", 32'(bus.busy), 32'h0);
      chk("t6_spur_rsp",  32'(bus.rsp_data), 32'h0);
    end
    bus.dp_done = 1'b0;
    bus.req = 4'b1000;
    run_job(3, 8'h3C, 2);
    bus.req = 4'b0000;
    tick();
    chk("t6_gnt_hold", 32'(bus.gnt_id), 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
